// File: rtl/alu_mdu.sv
// EX-stage execute unit: combinational ALU plus a multi-cycle multiply/divide unit that owns HI/LO.
// MDU handshake: md_start is sampled only while md_busy=0; an accepted mult/div holds md_busy high for its cycle count.
module alu_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  localparam int SHW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  output logic             md_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int HALF    = WIDTH / 2;
  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // ---------------- ALU ----------------
  logic [WIDTH-1:0] sum, diff;
  logic [SHW-1:0]   vsh;

  assign sum  = a + b;
  assign diff = a - b;
  assign vsh  = a[SHW-1:0];
  assign zero = (a == b);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_op)
      4'd0: begin
        result   = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        result   = diff;
        overflow = (a[WIDTH-1] == ~b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2:  result = a & b;
      4'd3:  result = a | b;
      4'd4:  result = a ^ b;
      4'd5:  result = ~(a | b);
      4'd6:  result = {b[HALF-1:0], {HALF{1'b0}}};
      4'd7:  result = a | {{HALF{1'b0}}, b[HALF-1:0]};
      4'd8:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9:  result = {{(WIDTH-1){1'b0}}, (a < b)};
      4'd10: result = b << shamt;
      4'd11: result = b >> shamt;
      4'd12: result = $signed(b) >>> shamt;
      4'd13: result = b << vsh;
      4'd14: result = b >> vsh;
      4'd15: result = $signed(b) >>> vsh;
      default: result = '0;
    endcase
  end

  // ---------------- MDU arithmetic (evaluated on the accept cycle) ----------------
  // md_op bit 0 clear selects the signed variant for codes 0..3.
  logic                 op_signed;
  logic [2*WIDTH-1:0]   ext_a, ext_b, product;
  logic [WIDTH-1:0]     abs_a, abs_b, div_b, quo_u, rem_u, quo, rem;
  logic                 neg_a, neg_b;

  assign op_signed = ~md_op[0];
  assign ext_a     = op_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign ext_b     = op_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign product   = ext_a * ext_b;

  assign neg_a = op_signed & a[WIDTH-1];
  assign neg_b = op_signed & b[WIDTH-1];
  assign abs_a = neg_a ? (~a + 1'b1) : a;
  assign abs_b = neg_b ? (~b + 1'b1) : b;
  assign div_b = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
  assign quo_u = abs_a / div_b;
  assign rem_u = abs_a % div_b;

  // Most-negative / -1 falls out naturally: |a| negated back wraps to most-negative, remainder 0.
  always_comb begin
    quo = (neg_a ^ neg_b) ? (~quo_u + 1'b1) : quo_u;
    rem = neg_a ? (~rem_u + 1'b1) : rem_u;
    if (b == '0) begin
      quo = '1;
      rem = a;
    end
  end

  // ---------------- MDU control FSM ----------------
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} md_state_t;

  md_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          case (md_op)
            3'd0, 3'd1: begin
              state_d   = MUL;
              cnt_d     = CW'(MULT_CYCLES);
              pend_hi_d = product[2*WIDTH-1:WIDTH];
              pend_lo_d = product[WIDTH-1:0];
            end
            3'd2, 3'd3: begin
              state_d   = DIV;
              cnt_d     = CW'(DIV_CYCLES);
              pend_hi_d = rem;
              pend_lo_d = quo;
            end
            3'd4:    hi_d = a;
            3'd5:    lo_d = a;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign md_busy = (state_q != IDLE);
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: a 32-bit default instance and a 16-bit instance with short latencies.
module tb_alu_mdu;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // 32-bit instance
  logic [31:0] a32, b32, result32, hi32, lo32;
  logic [3:0]  alu_op32;
  logic [4:0]  shamt32;
  logic        zero32, overflow32, md_start32, md_busy32;
  logic [2:0]  md_op32;

  // 16-bit instance
  logic [15:0] a16, b16, result16, hi16, lo16;
  logic [3:0]  alu_op16;
  logic [3:0]  shamt16;
  logic        zero16, overflow16, md_start16, md_busy16;
  logic [2:0]  md_op16;

  int passed = 0;
  int total  = 0;

  alu_mdu dut32 (
    .clk(clk), .reset_n(reset_n), .a(a32), .b(b32), .alu_op(alu_op32), .shamt(shamt32),
    .result(result32), .zero(zero32), .overflow(overflow32), .md_start(md_start32),
    .md_op(md_op32), .md_busy(md_busy32), .hi(hi32), .lo(lo32)
  );

  alu_mdu #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset_n(reset_n), .a(a16), .b(b16), .alu_op(alu_op16), .shamt(shamt16),
    .result(result16), .zero(zero16), .overflow(overflow16), .md_start(md_start16),
    .md_op(md_op16), .md_busy(md_busy16), .hi(hi16), .lo(lo16)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ov;
    logic        z;
  } alu_vec_t;

  alu_vec_t vecs[18];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one md request for a single edge; afterwards the DUT is in its first busy cycle.
  task automatic issue(input bit sel16, input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
    if (sel16) begin
      md_op16 = op; a16 = va[15:0]; b16 = vb[15:0]; md_start16 = 1'b1;
    end else begin
      md_op32 = op; a32 = va; b32 = vb; md_start32 = 1'b1;
    end
    tick();
    md_start16 = 1'b0;
    md_start32 = 1'b0;
  endtask

  // Counts cycles with md_busy=1 starting at the current cycle; bounded at 200.
  task automatic wait_idle(input bit sel16, output int n);
    n = 0;
    while ((sel16 ? md_busy16 : md_busy32) && n < 200) begin
      n++;
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b1;
    a32 = '0; b32 = '0; alu_op32 = '0; shamt32 = '0; md_start32 = 1'b0; md_op32 = '0;
    a16 = '0; b16 = '0; alu_op16 = '0; shamt16 = '0; md_start16 = 1'b0; md_op16 = '0;
    #3 reset_n = 1'b0;
    #4;
    total++; if (md_busy32 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", md_busy32); else passed++;
    total++; if (hi32 !== 32'h0) $display("FAIL reset_hi: got %h expected 0", hi32); else passed++;
    total++; if (lo32 !== 32'h0) $display("FAIL reset_lo: got %h expected 0", lo32); else passed++;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    total++; if (md_busy16 !== 1'b0 || hi16 !== 16'h0 || lo16 !== 16'h0)
      $display("FAIL reset16: got busy=%b hi=%h lo=%h expected 0/0/0", md_busy16, hi16, lo16); else passed++;
  endtask

  task automatic test_alu();
    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1, 1'b0};
    vecs[1]  = '{4'd1,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0, 1'b1};
    vecs[2]  = '{4'd1,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1, 1'b0};
    vecs[3]  = '{4'd8,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1'b0};
    vecs[4]  = '{4'd9,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0, 1'b0};
    vecs[5]  = '{4'd12, 32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0};
    vecs[6]  = '{4'd6,  32'hDEAD0000, 32'h00001234, 5'd0,  32'h12340000, 1'b0, 1'b0};
    vecs[7]  = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0};
    vecs[8]  = '{4'd5,  32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[9]  = '{4'd7,  32'h12340000, 32'hFFFF5678, 5'd0,  32'h12345678, 1'b0, 1'b0};
    vecs[10] = '{4'd14, 32'h00000024, 32'h80000000, 5'd0,  32'h08000000, 1'b0, 1'b0};
    vecs[11] = '{4'd10, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0};
    vecs[12] = '{4'd4,  32'hA5A5A5A5, 32'hFFFFFFFF, 5'd0,  32'h5A5A5A5A, 1'b0, 1'b0};
    vecs[13] = '{4'd15, 32'h0000001F, 32'h80000000, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[14] = '{4'd3,  32'h0000000F, 32'h000000F0, 5'd0,  32'h000000FF, 1'b0, 1'b0};
    vecs[15] = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0, 1'b0};
    vecs[16] = '{4'd11, 32'h00000000, 32'hF0000000, 5'd28, 32'h0000000F, 1'b0, 1'b0};
    vecs[17] = '{4'd13, 32'h00000021, 32'h00000003, 5'd0,  32'h00000006, 1'b0, 1'b0};
    for (int i = 0; i < 18; i++) begin
      alu_op32 = vecs[i].op; a32 = vecs[i].a; b32 = vecs[i].b; shamt32 = vecs[i].sh;
      #1;
      total++; if (result32 !== vecs[i].res)
        $display("FAIL alu_result[%0d]: got %h expected %h", i, result32, vecs[i].res); else passed++;
      total++; if (overflow32 !== vecs[i].ov)
        $display("FAIL alu_overflow[%0d]: got %b expected %b", i, overflow32, vecs[i].ov); else passed++;
      total++; if (zero32 !== vecs[i].z)
        $display("FAIL alu_zero[%0d]: got %b expected %b", i, zero32, vecs[i].z); else passed++;
    end
    alu_op32 = '0; a32 = '0; b32 = '0; shamt32 = '0;
  endtask

  task automatic test_mthi();
    issue(1'b0, 3'd4, 32'h0000ABCD, 32'h0);
    total++; if (hi32 !== 32'h0000ABCD) $display("FAIL mthi_hi: got %h expected 0000abcd", hi32); else passed++;
    total++; if (md_busy32 !== 1'b0) $display("FAIL mthi_busy: got %b expected 0", md_busy32); else passed++;
    total++; if (lo32 !== 32'h0) $display("FAIL mthi_lo: got %h expected 0", lo32); else passed++;
  endtask

  task automatic test_mult();
    int n;
    issue(1'b0, 3'd0, 32'hFFFFFFFD, 32'h00000005);
    a32 = 32'h12345678; b32 = 32'h9ABCDEF0;
    total++; if (md_busy32 !== 1'b1) $display("FAIL mult_busy_start: got %b expected 1", md_busy32); else passed++;
    total++; if (hi32 !== 32'h0000ABCD) $display("FAIL mult_hi_held: got %h expected 0000abcd", hi32); else passed++;
    wait_idle(1'b0, n);
    total++; if (n !== 5) $display("FAIL mult_busy_len: got %0d expected 5", n); else passed++;
    total++; if (hi32 !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h expected ffffffff", hi32); else passed++;
    total++; if (lo32 !== 32'hFFFFFFF1) $display("FAIL mult_lo: got %h expected fffffff1", lo32); else passed++;

    issue(1'b0, 3'd1, 32'hFFFFFFFF, 32'h00000002);
    wait_idle(1'b0, n);
    total++; if (n !== 5) $display("FAIL multu_busy_len: got %0d expected 5", n); else passed++;
    total++; if (hi32 !== 32'h1 || lo32 !== 32'hFFFFFFFE)
      $display("FAIL multu_hilo: got %h_%h expected 00000001_fffffffe", hi32, lo32); else passed++;
  endtask

  task automatic test_divide();
    int n;
    issue(1'b0, 3'd2, 32'h00000007, 32'hFFFFFFFE);
    wait_idle(1'b0, n);
    total++; if (n !== 10) $display("FAIL div_busy_len: got %0d expected 10", n); else passed++;
    total++; if (hi32 !== 32'h1 || lo32 !== 32'hFFFFFFFD)
      $display("FAIL div_7_m2: got %h_%h expected 00000001_fffffffd", hi32, lo32); else passed++;

    issue(1'b0, 3'd2, 32'hFFFFFFF9, 32'h00000002);
    wait_idle(1'b0, n);
    total++; if (hi32 !== 32'hFFFFFFFF || lo32 !== 32'hFFFFFFFD)
      $display("FAIL div_m7_2: got %h_%h expected ffffffff_fffffffd", hi32, lo32); else passed++;

    issue(1'b0, 3'd3, 32'h00000007, 32'h00000000);
    wait_idle(1'b0, n);
    total++; if (n !== 10) $display("FAIL divu_zero_busy_len: got %0d expected 10", n); else passed++;
    total++; if (hi32 !== 32'h7 || lo32 !== 32'hFFFFFFFF)
      $display("FAIL divu_by_zero: got %h_%h expected 00000007_ffffffff", hi32, lo32); else passed++;

    issue(1'b0, 3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(1'b0, n);
    total++; if (hi32 !== 32'h0 || lo32 !== 32'h80000000)
      $display("FAIL div_minneg_m1: got %h_%h expected 00000000_80000000", hi32, lo32); else passed++;

    issue(1'b0, 3'd3, 32'hFFFFFFF9, 32'h00000002);
    wait_idle(1'b0, n);
    total++; if (hi32 !== 32'h1 || lo32 !== 32'h7FFFFFFC)
      $display("FAIL divu_big: got %h_%h expected 00000001_7ffffffc", hi32, lo32); else passed++;
  endtask

  task automatic test_ignore_busy();
    int n;
    issue(1'b0, 3'd4, 32'h11111111, 32'h0);
    issue(1'b0, 3'd0, 32'h00000003, 32'h00000004);
    tick();
    md_op32 = 3'd2; a32 = 32'd100; b32 = 32'd7; md_start32 = 1'b1;
    tick();
    md_op32 = 3'd4; a32 = 32'h00005555; md_start32 = 1'b1;
    tick();
    md_start32 = 1'b0;
    total++; if (hi32 !== 32'h11111111) $display("FAIL ignore_hi_held: got %h expected 11111111", hi32); else passed++;
    wait_idle(1'b0, n);
    total++; if (n !== 2) $display("FAIL ignore_remaining_busy: got %0d expected 2", n); else passed++;
    total++; if (hi32 !== 32'h0 || lo32 !== 32'd12)
      $display("FAIL ignore_result: got %h_%h expected 00000000_0000000c", hi32, lo32); else passed++;
    tick();
    total++; if (md_busy32 !== 1'b0) $display("FAIL ignore_no_restart: got %b expected 0", md_busy32); else passed++;
  endtask

  task automatic test_reset_mid_div();
    int n;
    issue(1'b0, 3'd2, 32'd100, 32'd7);
    tick(); tick(); tick();
    total++; if (md_busy32 !== 1'b1) $display("FAIL rst_mid_busy_before: got %b expected 1", md_busy32); else passed++;
    #2 reset_n = 1'b0;
    #1;
    total++; if (md_busy32 !== 1'b0 || hi32 !== 32'h0 || lo32 !== 32'h0)
      $display("FAIL rst_mid_async: got busy=%b hi=%h lo=%h expected 0/0/0", md_busy32, hi32, lo32); else passed++;
    tick();
    reset_n = 1'b1;
    tick();
    total++; if (md_busy32 !== 1'b0) $display("FAIL rst_mid_after: got %b expected 0", md_busy32); else passed++;
    issue(1'b0, 3'd0, 32'd6, 32'd7);
    wait_idle(1'b0, n);
    total++; if (n !== 5) $display("FAIL rst_mult_busy_len: got %0d expected 5", n); else passed++;
    total++; if (hi32 !== 32'h0 || lo32 !== 32'd42)
      $display("FAIL rst_mult_result: got %h_%h expected 00000000_0000002a", hi32, lo32); else passed++;
  endtask

  task automatic test_width16();
    int n;
    issue(1'b1, 3'd0, 32'h0000FFFD, 32'h00000005);
    wait_idle(1'b1, n);
    total++; if (n !== 1) $display("FAIL w16_mult_busy_len: got %0d expected 1", n); else passed++;
    total++; if (hi16 !== 16'hFFFF || lo16 !== 16'hFFF1)
      $display("FAIL w16_mult: got %h_%h expected ffff_fff1", hi16, lo16); else passed++;

    issue(1'b1, 3'd1, 32'h0000FFFF, 32'h00000002);
    wait_idle(1'b1, n);
    total++; if (hi16 !== 16'h0001 || lo16 !== 16'hFFFE)
      $display("FAIL w16_multu: got %h_%h expected 0001_fffe", hi16, lo16); else passed++;

    issue(1'b1, 3'd2, 32'h00000007, 32'h0000FFFE);
    wait_idle(1'b1, n);
    total++; if (n !== 3) $display("FAIL w16_div_busy_len: got %0d expected 3", n); else passed++;
    total++; if (hi16 !== 16'h0001 || lo16 !== 16'hFFFD)
      $display("FAIL w16_div: got %h_%h expected 0001_fffd", hi16, lo16); else passed++;

    issue(1'b1, 3'd3, 32'h00000007, 32'h00000000);
    wait_idle(1'b1, n);
    total++; if (hi16 !== 16'h0007 || lo16 !== 16'hFFFF)
      $display("FAIL w16_divu_zero: got %h_%h expected 0007_ffff", hi16, lo16); else passed++;

    issue(1'b1, 3'd2, 32'h00008000, 32'h0000FFFF);
    wait_idle(1'b1, n);
    total++; if (hi16 !== 16'h0000 || lo16 !== 16'h8000)
      $display("FAIL w16_minneg: got %h_%h expected 0000_8000", hi16, lo16); else passed++;

    alu_op16 = 4'd0; a16 = 16'h7FFF; b16 = 16'h0001;
    #1;
    total++; if (result16 !== 16'h8000 || overflow16 !== 1'b1)
      $display("FAIL w16_add_ovf: got %h/%b expected 8000/1", result16, overflow16); else passed++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mthi();
    test_mult();
    test_divide();
    test_ignore_busy();
    test_reset_mid_div();
    test_width16();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
